// File: rtl/srambank_pkg.sv
// rtl/srambank_pkg.sv - shared types and bank geometry for SRAM bank controllers
package srambank_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int BANK_AW = 9;
  localparam int BANK_DW = 20;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: request vector + last-grant pointer -> one-hot grant and index
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Search starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any                         = 1'b1;
        grant[(int'(ptr) + k) % N]  = 1'b1;
        idx                         = PW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/srambank_arbiter.sv
// rtl/srambank_arbiter.sv - zero-fills one SRAM bank after reset, then round-robin shares it among requesters
module srambank_arbiter
  import srambank_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = BANK_AW,
  parameter int DW   = BANK_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  output logic             init_done,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_data,
  output logic [AW-1:0]    ADDRESS,
  output logic [DW-1:0]    wd,
  output logic             banksel,
  output logic             read,
  output logic             write,
  input  logic [DW-1:0]    dataout
);

  localparam int PW = $clog2(NREQ);

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_ptr;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gidx;
  logic [NREQ-1:0] grant;
  logic            gany;
  logic            xfer;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // The bank latches its read data and holds it until the next read.
  assign rsp_data = dataout;

  always_comb begin
    state_nxt = state;
    init_done = 1'b0;
    req_ready = '0;
    banksel   = 1'b0;
    read      = 1'b0;
    write     = 1'b0;
    ADDRESS   = '0;
    wd        = '0;
    xfer      = 1'b0;
    case (state)
      INIT: begin
        banksel = 1'b1;
        write   = 1'b1;
        ADDRESS = clr_ptr;
        if (clr_ptr == {AW{1'b1}}) state_nxt = RUN;
      end
      RUN: begin
        init_done = 1'b1;
        if (clr_req) begin
          state_nxt = INIT;
        end else if (gany) begin
          xfer      = 1'b1;
          req_ready = grant;
          banksel   = 1'b1;
          write     = req_write[gidx];
          read      = !req_write[gidx];
          ADDRESS   = req_addr[int'(gidx)*AW +: AW];
          wd        = req_wdata[int'(gidx)*DW +: DW];
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  // clr_ptr wraps to 0 on the final fill write, leaving it ready for the next clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      clr_ptr   <= '0;
      rr_ptr    <= PW'(NREQ - 1);
      rsp_valid <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= (xfer && read) ? grant : '0;
      if (state == INIT) clr_ptr <= clr_ptr + 1'b1;
      else               clr_ptr <= '0;
      if (xfer) rr_ptr <= gidx;
    end
  end

endmodule

// File: tb/tb_srambank_arbiter.sv
// tb/tb_srambank_arbiter.sv - directed bench for srambank_arbiter with a behavioural 512x20 bank
module tb_srambank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_req;
  logic        init_done;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [17:0] req_addr;
  logic [39:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [19:0] rsp_data;
  logic [8:0]  ADDRESS;
  logic [19:0] wd;
  logic        banksel;
  logic        read;
  logic        write;
  logic [19:0] dataout = 20'h0;

  int checks = 0;
  int errors = 0;

  logic [19:0] mem [512] = '{default: 20'hFFFFF};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (banksel) begin
      if (write) mem[ADDRESS] <= wd;
      if (read)  dataout <= mem[ADDRESS];
    end
  end

  srambank_arbiter #(.NREQ(2), .AW(9), .DW(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req   (clr_req),
    .init_done (init_done),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ADDRESS   (ADDRESS),
    .wd        (wd),
    .banksel   (banksel),
    .read      (read),
    .write     (write),
    .dataout   (dataout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of the first INIT cycle; leaves at the negedge of the first RUN cycle.
  task automatic init_run(input string tag);
    int bad;
    int nz;
    bad = 0;
    for (int c = 0; c < 512; c++) begin
      if (ADDRESS !== 9'(c) || write !== 1'b1 || read !== 1'b0 || banksel !== 1'b1 ||
          wd !== 20'h0 || init_done !== 1'b0 || req_ready !== 2'b00)
        bad++;
      @(negedge clk);
    end
    chk({tag, "_seq"}, bad, 0);
    #1;
    chk({tag, "_done"}, {31'h0, init_done}, 1);
    nz = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== 20'h0) nz++;
    chk({tag, "_memzero"}, nz, 0);
  endtask

  logic [1:0] exp_rdy;
  logic [1:0] exp_rsp;

  initial begin
    rst_n     = 1'b0;
    clr_req   = 1'b0;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = {9'd5, 9'd5};
    req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_init_done", {31'h0, init_done}, 0);
    chk("rst_addr", {23'h0, ADDRESS}, 0);
    chk("rst_write", {31'h0, write}, 1);
    chk("rst_ready", {30'h0, req_ready}, 0);
    chk("rst_rsp", {30'h0, rsp_valid}, 0);

    // 1: zero-fill after reset release
    rst_n = 1'b1;
    init_run("init1");

    // 2: both read addr 5, grants alternate starting at 0
    for (int k = 0; k < 4; k++) begin
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_rsp = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
      chk("rr_ready", {30'h0, req_ready}, {30'h0, exp_rdy});
      chk("rr_rsp", {30'h0, rsp_valid}, {30'h0, exp_rsp});
      chk("rr_read", {31'h0, read}, 1);
      if (k > 0) chk("rr_data", {12'h0, rsp_data}, 0);
      @(negedge clk);
      #1;
    end
    req_valid = 2'b00;
    #1;
    chk("idle_rsp", {30'h0, rsp_valid}, 32'h2);
    chk("idle_banksel", {31'h0, banksel}, 0);
    chk("idle_addr", {23'h0, ADDRESS}, 0);

    // 3: req0 writes 0x1FF, then req1 reads it back
    @(negedge clk);
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr  = {9'h1FF, 9'h1FF};
    req_wdata = {20'h0, 20'hABCDE};
    #1;
    chk("wr_ready", {30'h0, req_ready}, 32'h1);
    chk("wr_write", {30'h0, write, read}, 32'h2);
    chk("wr_wd", {12'h0, wd}, 32'hABCDE);
    chk("wr_addr", {23'h0, ADDRESS}, 32'h1FF);
    @(negedge clk);
    req_valid = 2'b10;
    req_write = 2'b00;
    #1;
    chk("raw_ready", {30'h0, req_ready}, 32'h2);
    chk("raw_read", {31'h0, read}, 1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("raw_rsp", {30'h0, rsp_valid}, 32'h2);
    chk("raw_data", {12'h0, rsp_data}, 32'hABCDE);

    // 4: single requester back-to-back reads, write in a response cycle
    @(negedge clk);
    req_valid = 2'b10;
    req_addr  = {9'h1FF, 9'h1FF};
    #1;
    chk("b2b0_ready", {30'h0, req_ready}, 32'h2);
    @(negedge clk);
    req_addr = {9'd5, 9'h1FF};
    #1;
    chk("b2b1_ready", {30'h0, req_ready}, 32'h2);
    chk("b2b1_rsp", {30'h0, rsp_valid}, 32'h2);
    chk("b2b1_data", {12'h0, rsp_data}, 32'hABCDE);
    @(negedge clk);
    req_addr = {9'h1FF, 9'h1FF};
    #1;
    chk("b2b2_ready", {30'h0, req_ready}, 32'h2);
    chk("b2b2_rsp", {30'h0, rsp_valid}, 32'h2);
    chk("b2b2_data", {12'h0, rsp_data}, 0);
    @(negedge clk);
    req_valid = 2'b01;
    req_write = 2'b01;
    req_wdata = {20'h0, 20'h12345};
    #1;
    chk("b2b3_ready", {30'h0, req_ready}, 32'h1);
    chk("b2b3_rsp", {30'h0, rsp_valid}, 32'h2);
    chk("b2b3_data", {12'h0, rsp_data}, 32'hABCDE);
    @(negedge clk);
    req_valid = 2'b10;
    req_write = 2'b00;
    #1;
    chk("rdw_ready", {30'h0, req_ready}, 32'h2);
    chk("rdw_rsp", {30'h0, rsp_valid}, 0);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("rdw_rsp2", {30'h0, rsp_valid}, 32'h2);
    chk("rdw_data", {12'h0, rsp_data}, 32'h12345);

    // 5: clr_req while both request, with a response still in flight
    @(negedge clk);
    req_valid = 2'b10;
    #1;
    chk("pre_clr_ready", {30'h0, req_ready}, 32'h2);
    @(negedge clk);
    req_valid = 2'b11;
    clr_req   = 1'b1;
    #1;
    chk("clr_ready", {30'h0, req_ready}, 0);
    chk("clr_banksel", {31'h0, banksel}, 0);
    chk("clr_rsp", {30'h0, rsp_valid}, 32'h2);
    chk("clr_data", {12'h0, rsp_data}, 32'h12345);
    @(negedge clk);
    clr_req = 1'b0;
    chk("clr_rsp_off", {30'h0, rsp_valid}, 0);
    init_run("init2");
    req_valid = 2'b10;
    req_addr  = {9'h1FF, 9'h1FF};
    #1;
    chk("post_clr_ready", {30'h0, req_ready}, 32'h2);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("post_clr_rsp", {30'h0, rsp_valid}, 32'h2);
    chk("post_clr_data", {12'h0, rsp_data}, 0);

    // 6: reset with a pending response, and reset mid-clear
    @(negedge clk);
    req_valid = 2'b10;
    req_addr  = {9'd5, 9'd5};
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("pend_rsp", {30'h0, rsp_valid}, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("arst_rsp", {30'h0, rsp_valid}, 0);
    chk("arst_done", {31'h0, init_done}, 0);
    chk("arst_addr", {23'h0, ADDRESS}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("mid_addr", {23'h0, ADDRESS}, 100);
    chk("mid_done", {31'h0, init_done}, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", {23'h0, ADDRESS}, 0);
    chk("mid_rst_write", {31'h0, write}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("restart_addr0", {23'h0, ADDRESS}, 0);
    @(negedge clk);
    chk("restart_addr1", {23'h0, ADDRESS}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
